// File: rtl/y_argmax.sv
// y_argmax: passive monitor on the pu output-buffer write stream.
// Collects NUM_CLASS FP32 scores per image, picks the largest by signed
// IEEE-754 ordering (lowest index wins a tie), and queues
// {class, raw score, image} in a small first-word-fall-through FIFO.
// The FIFO is drained by a valid/ready consumer.
module y_argmax #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int NUM_CLASS   = 10,
    parameter int ADDR_STRIDE = 4,
    parameter int IMG_NUM     = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prcss_start,
    input  logic                  y_buf_en,
    input  logic                  y_buf_wr_en,
    input  logic [ADDR_WIDTH-1:0] y_buf_addr,
    input  logic [DATA_WIDTH-1:0] y_buf_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [3:0]            res_class,
    output logic [DATA_WIDTH-1:0] res_score,
    output logic [7:0]            res_img,
    output logic                  run_done,
    output logic                  addr_err,
    output logic                  ovf_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0]            cls;
        logic [DATA_WIDTH-1:0] score;
        logic [7:0]            img;
    } result_t;

    // Argmax state
    logic [3:0]            cls_cnt;
    logic [7:0]            img_cnt;
    logic [DATA_WIDTH-1:0] best_key;
    logic [3:0]            best_idx;

    // Combinational datapath
    logic                  clear;
    logic                  sample;
    logic                  last;
    logic                  take_new;
    logic [DATA_WIDTH-1:0] key_in;
    logic [DATA_WIDTH-1:0] win_key;
    logic [DATA_WIDTH-1:0] win_raw;
    logic [3:0]            win_idx;
    logic [ADDR_WIDTH-1:0] exp_addr;

    // Result FIFO
    result_t               mem [FIFO_DEPTH];
    result_t               head;
    result_t               entry;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  do_push;
    logic                  drop;

    // Score ordering key, running winner and FIFO handshake decisions.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        clear    = !rst_n || prcss_start;
        sample   = y_buf_en && y_buf_wr_en && !run_done && !clear;
        last     = (cls_cnt == 4'(NUM_CLASS - 1));

        // Map FP32 onto an unsigned scale: negatives invert, positives set the MSB.
        key_in   = y_buf_data[DATA_WIDTH-1] ? ~y_buf_data
                                            : {1'b1, y_buf_data[DATA_WIDTH-2:0]};
        take_new = (cls_cnt == 4'd0) || (key_in > best_key);
        win_key  = take_new ? key_in  : best_key;
        win_idx  = take_new ? cls_cnt : best_idx;
        // The key is reversible, so the raw score is recovered instead of stored.
        win_raw  = win_key[DATA_WIDTH-1] ? {1'b0, win_key[DATA_WIDTH-2:0]} : ~win_key;

        // The snooped bus carries ADDR_WIDTH bits, so the check is modulo 2^ADDR_WIDTH.
        exp_addr = ADDR_WIDTH'((int'(img_cnt) * NUM_CLASS + int'(cls_cnt)) * ADDR_STRIDE);

        full     = (count == CNT_W'(FIFO_DEPTH));
        res_valid = (count != '0);
        pop      = res_valid && res_ready && !clear;
        push     = sample && last;
        do_push  = push && (!full || pop);
        drop     = push && full && !pop;

        entry.cls   = win_idx;
        entry.score = win_raw;
        entry.img   = img_cnt;

        head      = mem[rd_ptr];
        res_class = res_valid ? head.cls   : '0;
        res_score = res_valid ? head.score : '0;
        res_img   = res_valid ? head.img   : '0;
    end

    // Counters, running best and sticky flags.
    // NOTE: sequential state is assigned with <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            cls_cnt  <= '0;
            img_cnt  <= '0;
            best_key <= '0;
            best_idx <= '0;
            run_done <= 1'b0;
            addr_err <= 1'b0;
            ovf_err  <= 1'b0;
        end else if (sample) begin
            if (y_buf_addr != exp_addr) begin
                addr_err <= 1'b1;
            end
            best_key <= win_key;
            best_idx <= win_idx;
            if (last) begin
                cls_cnt <= '0;
                img_cnt <= img_cnt + 8'd1;
                if (img_cnt == 8'(IMG_NUM - 1)) begin
                    run_done <= 1'b1;
                end
                if (drop) begin
                    ovf_err <= 1'b1;
                end
            end else begin
                cls_cnt <= cls_cnt + 4'd1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write.
    // NOTE: storage is not reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= entry;
        end
    end

endmodule

// File: doc/y_argmax.md
Name: y_argmax

Overview:
- Passive monitor on the pu output-buffer write stream (y_buf_en / y_buf_wr_en / y_buf_addr / y_buf_data).
- For each image it collects the NUM_CLASS FP32 scores and computes the predicted class by signed IEEE-754 argmax.
- Each result is pushed into a small output FIFO drained by a valid/ready consumer (LED/AXI reporting logic).
- It sits beside the y buffer, downstream of pu, and never drives the buffer.

Parameters:
- DATA_WIDTH, 32, score width (FP32).
- ADDR_WIDTH, 6, y buffer address width, equal to $clog2(Y_BUF_DEPTH) with Y_BUF_DEPTH = 40.
- NUM_CLASS, 10, scores per image.
- ADDR_STRIDE, 4, address increment between consecutive scores.
- IMG_NUM, 1, images per run.
- FIFO_DEPTH, 4, result FIFO entries (power of 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- prcss_start  in  1  one-cycle pulse; clears counters, argmax state, FIFO and flags for a new run.
- y_buf_en  in  1  snooped buffer enable.
- y_buf_wr_en  in  1  snooped write enable.
- y_buf_addr  in  ADDR_WIDTH  snooped write address.
- y_buf_data  in  DATA_WIDTH  snooped FP32 score.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer accepts head.
- res_class  out  4  predicted class index 0..NUM_CLASS-1.
- res_score  out  DATA_WIDTH  winning raw FP32 score.
- res_img  out  8  image index of the head result.
- run_done  out  1  sticky; set when IMG_NUM results have been produced.
- addr_err  out  1  sticky; a write address did not match the expected address.
- ovf_err  out  1  sticky; a result was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FIFO empty, cls_cnt=0, img_cnt=0, best_key=0, best_idx=0.
- prcss_start has the same clearing effect as reset. A write sampled in the same cycle is ignored.
- Sample condition: y_buf_en && y_buf_wr_en at the rising clk edge. Any other cycle leaves the state unchanged.
- Expected address = (img_cnt*NUM_CLASS + cls_cnt)*ADDR_STRIDE. On a mismatch, addr_err is set. The score is still processed using cls_cnt as its index, never the address.
- Ordering key: for sign=1, key = ~data; otherwise key = data ^ 32'h8000_0000. Comparison is unsigned on the key.
  - -0 < +0.
  - NaNs order by their raw key and get no special handling.
- cls_cnt==0: best_key=key and best_idx=0 unconditionally.
- Otherwise: replace best only if key > best_key (strict), so a tie keeps the lower index.
- cls_cnt counts 0..NUM_CLASS-1 and wraps to 0 after the last score.
- Last score (cls_cnt==NUM_CLASS-1): the final winner is computed combinationally from the current best and the incoming score, then pushed {idx, raw score, img_cnt} at the same edge. img_cnt then increments.
- Latency: the last score is sampled at edge N; res_valid is 1 in the cycle after edge N (when the FIFO was empty).
- FIFO is first-word-fall-through; res_* show the head while res_valid=1.
  - A pop occurs on res_valid && res_ready.
  - Push when full with no pop in the same cycle: the result is dropped and ovf_err is set.
  - Push when full with a pop in the same cycle: both succeed and the count is unchanged.
  - Push and pop on a non-full FIFO: the count is unchanged.
- run_done is set at the edge that pushes, or drops, the IMG_NUM-th result.
- Writes sampled after run_done is set are ignored: no address check, no push.
- A reset mid-image discards the partial argmax. The next write sampled is treated as class 0 of image 0.
- Handshake rules:
  - res_class, res_score and res_img stay stable while res_valid=1 and res_ready=0.
  - res_valid does not depend combinationally on res_ready.

Test Plan:
- Scores 0.1..1.0 (class 9 largest) written at addr 0,4,..,36 back-to-back with res_ready=1 -> res_valid one cycle after the last write; res_class=9, res_score=32'h3F80_0000, res_img=0, run_done=1, no error flags.
- All-negative scores {-5,-1,-3,...} with class 1 = -1.0 -> res_class=1, res_score=32'hBF80_0000.
- Ties: classes 2 and 7 both 2.0 and the rest 0 -> res_class=2. Class 0 = -0.0 and class 1 = +0.0, all others negative -> res_class=1.
- IMG_NUM=6, FIFO_DEPTH=4, res_ready=0 throughout -> four entries held, ovf_err=1 after image 4. Then raise res_ready -> images 0..3 pop in order, res_img = 0,1,2,3.
- Class 3 written to addr 16 instead of 12 -> addr_err=1; argmax still treats that score as index 3.
- Assert rst_n=0 for one cycle after 5 scores, then write 10 fresh scores -> single result computed from the fresh scores only; prcss_start mid-run behaves identically.
